// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-ported memory between the fetch port and the load/store port.
// Each access runs IDLE -> ISSUE -> [WAIT] -> RESP; data accesses win, with a fetch starvation guard.
module mem_bus_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_valid_o,
    input  logic        d_rd_req_i,
    input  logic        d_wr_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_wr_sel_i,
    input  logic [31:0] d_wr_data_i,
    output logic [31:0] d_rd_data_o,
    output logic        d_rd_valid_o,
    output logic        d_wr_done_o,
    output logic        hold_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned BurstW = $clog2(MAX_DBURST + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
    typedef enum logic [1:0] {MstIf, MstRd, MstWr} master_e;

    state_e            state;
    master_e           master;
    logic [1:0]        lat_cnt;
    logic [BurstW-1:0] burst_cnt;
    logic              burst_full;
    logic              force_fetch;

    assign burst_full  = (burst_cnt == BurstW'(MAX_DBURST));
    assign force_fetch = if_req_i && burst_full;
    assign hold_o      = rst & (d_rd_req_i | d_wr_req_i) & ~d_rd_valid_o & ~d_wr_done_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= StIdle;
            master       <= MstIf;
            lat_cnt      <= '0;
            burst_cnt    <= '0;
            if_data_o    <= '0;
            if_valid_o   <= 1'b0;
            d_rd_data_o  <= '0;
            d_rd_valid_o <= 1'b0;
            d_wr_done_o  <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_sel_o    <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            // Strobes and pulses are one cycle wide unless re-asserted below.
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            if_valid_o   <= 1'b0;
            d_rd_valid_o <= 1'b0;
            d_wr_done_o  <= 1'b0;
            case (state)
                StIdle: begin
                    if (!if_req_i) begin
                        burst_cnt <= '0;
                    end
                    if (force_fetch || (if_req_i && !d_wr_req_i && !d_rd_req_i)) begin
                        master     <= MstIf;
                        mem_addr_o <= if_addr_i;
                        mem_sel_o  <= 4'hF;
                        mem_en_o   <= 1'b1;
                        burst_cnt  <= '0;
                        state      <= StIssue;
                    end else if (d_wr_req_i || d_rd_req_i) begin
                        master     <= d_wr_req_i ? MstWr : MstRd;
                        mem_addr_o <= d_addr_i;
                        mem_sel_o  <= d_wr_req_i ? d_wr_sel_i : 4'hF;
                        mem_en_o   <= 1'b1;
                        mem_we_o   <= d_wr_req_i;
                        if (d_wr_req_i) begin
                            mem_wdata_o <= d_wr_data_i;
                        end
                        if (if_req_i && !burst_full) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (master == MstWr) begin
                        d_wr_done_o <= 1'b1;
                        state       <= StResp;
                    end else begin
                        lat_cnt <= 2'(RD_LAT - 1);
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (lat_cnt == 2'd0) begin
                        if (master == MstIf) begin
                            if_data_o  <= mem_rdata_i;
                            if_valid_o <= 1'b1;
                        end else begin
                            d_rd_data_o  <= mem_rdata_i;
                            d_rd_valid_o <= 1'b1;
                        end
                        state <= StResp;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end
endmodule
